// File: rtl/button_pkg.sv
// Shared constants for the button emulator: timing defaults, widths and FSM encoding.
package button_pkg;

    localparam int unsigned TIMER_W = 24;
    localparam int unsigned CNT_W   = 4;

    localparam logic [TIMER_W-1:0] DEF_BOUNCE_TIME  = 24'd4800;
    localparam int unsigned        DEF_BOUNCE_EDGES = 4;
    localparam logic [TIMER_W-1:0] DEF_HOLD_TIME    = 24'd960000;
    localparam logic [TIMER_W-1:0] DEF_GAP_TIME     = 24'd960000;

    localparam logic [2:0] ST_IDLE           = 3'd0;
    localparam logic [2:0] ST_PRESS_BOUNCE   = 3'd1;
    localparam logic [2:0] ST_HOLD           = 3'd2;
    localparam logic [2:0] ST_RELEASE_BOUNCE = 3'd3;
    localparam logic [2:0] ST_GAP            = 3'd4;
    localparam logic [2:0] ST_FINISH         = 3'd5;

    typedef enum logic [2:0] {
        IDLE           = ST_IDLE,
        PRESS_BOUNCE   = ST_PRESS_BOUNCE,
        HOLD           = ST_HOLD,
        RELEASE_BOUNCE = ST_RELEASE_BOUNCE,
        GAP            = ST_GAP,
        FINISH         = ST_FINISH
    } state_t;

endpackage

// File: rtl/button_emulator_phase_timer.sv
// Phase timer: counts cycles from 0 after a clear and flags the last cycle of an i_limit-long phase.
module phase_timer
    import button_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic [TIMER_W-1:0] i_limit,
    output logic               o_expire_c
);

    logic [TIMER_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + TIMER_W'(1);
        end
    end

    assign o_expire_c = (r_cnt == (i_limit - TIMER_W'(1)));

endmodule

// File: rtl/button_emulator.sv
// Emulates a bouncing active-low push button: emits a burst of `count` timed presses on pmod.
module button_emulator
    import button_pkg::*;
#(
    parameter logic [TIMER_W-1:0] BOUNCE_TIME  = DEF_BOUNCE_TIME,
    parameter int unsigned        BOUNCE_EDGES = DEF_BOUNCE_EDGES,
    parameter logic [TIMER_W-1:0] HOLD_TIME    = DEF_HOLD_TIME,
    parameter logic [TIMER_W-1:0] GAP_TIME     = DEF_GAP_TIME
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             pmod,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] led
);

    localparam int unsigned        HALF_W    = 6;
    localparam logic [HALF_W-1:0]  LAST_HALF = HALF_W'(2 * BOUNCE_EDGES) - HALF_W'(1);
    localparam bit                 NO_BOUNCE = (BOUNCE_EDGES == 0);

    state_t             r_state;
    logic [HALF_W-1:0]  r_half;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_led;
    logic               r_pmod;
    logic               r_busy;
    logic               r_done;

    logic [TIMER_W-1:0] w_limit;
    logic               w_expire;
    logic               w_clear;

    // Phase length for the current state; untimed states keep the timer parked at zero.
    always_comb begin
        w_limit = GAP_TIME;
        unique case (r_state)
            PRESS_BOUNCE, RELEASE_BOUNCE: w_limit = BOUNCE_TIME;
            HOLD:                         w_limit = HOLD_TIME;
            default:                      w_limit = GAP_TIME;
        endcase
    end

    assign w_clear = w_expire || (r_state == IDLE) || (r_state == FINISH);

    phase_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .i_limit    (w_limit),
        .o_expire_c (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_half   <= '0;
            r_target <= '0;
            r_led    <= '0;
            r_pmod   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_led <= '0;
                        if (count == '0) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_target <= count;
                            r_half   <= '0;
                            r_pmod   <= 1'b0;
                            r_busy   <= 1'b1;
                            r_state  <= NO_BOUNCE ? HOLD : PRESS_BOUNCE;
                        end
                    end
                end
                PRESS_BOUNCE: begin
                    if (w_expire) begin
                        if (r_half == LAST_HALF) begin
                            r_half  <= '0;
                            r_pmod  <= 1'b0;
                            r_state <= HOLD;
                        end else begin
                            r_half <= r_half + HALF_W'(1);
                            r_pmod <= ~r_pmod;
                        end
                    end
                end
                HOLD: begin
                    if (w_expire) begin
                        r_pmod <= 1'b1;
                        r_half <= '0;
                        if (NO_BOUNCE) begin
                            r_led   <= r_led + CNT_W'(1);
                            r_state <= GAP;
                        end else begin
                            r_state <= RELEASE_BOUNCE;
                        end
                    end
                end
                RELEASE_BOUNCE: begin
                    if (w_expire) begin
                        if (r_half == LAST_HALF) begin
                            r_half  <= '0;
                            r_pmod  <= 1'b1;
                            r_led   <= r_led + CNT_W'(1);
                            r_state <= GAP;
                        end else begin
                            r_half <= r_half + HALF_W'(1);
                            r_pmod <= ~r_pmod;
                        end
                    end
                end
                GAP: begin
                    // r_led doubles as the press counter; it stops at the target so never wraps.
                    if (w_expire) begin
                        if (r_led == r_target) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= FINISH;
                        end else begin
                            r_half  <= '0;
                            r_pmod  <= 1'b0;
                            r_state <= NO_BOUNCE ? HOLD : PRESS_BOUNCE;
                        end
                    end
                end
                FINISH: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pmod = r_pmod;
    assign busy = r_busy;
    assign done = r_done;
    assign led  = r_led;

endmodule

// File: doc/button_emulator.md
BUTTON_EMULATOR -- requirements
Module: button_emulator

Interface
REQ-001 Parameter BOUNCE_TIME, default 24'd4800: cycles per bounce half-period.
REQ-002 Parameter BOUNCE_EDGES, default 4: bounce pulse pairs per transition; 0 disables bounce.
REQ-003 Parameter HOLD_TIME, default 24'd960000: cycles the line is held stably low per press.
REQ-004 Parameter GAP_TIME, default 24'd960000: cycles the line is held stably high after each release.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to emit a press burst.
REQ-008 count  input  4  number of presses to emit, sampled with start.
REQ-009 pmod  output  1  emulated button line, active-low, idle high, registered.
REQ-010 busy  output  1  high while a burst is in progress.
REQ-011 done  output  1  one-cycle pulse when a burst completes.
REQ-012 led  output  4  presses emitted in the current or last burst.

Function
REQ-013 FSM states SHALL be IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, GAP, FINISH.
REQ-014 IDLE: start=1 with count!=0 SHALL latch count, clear led, and enter PRESS_BOUNCE, or HOLD if BOUNCE_EDGES=0.
REQ-015 IDLE: start=1 with count=0 SHALL enter FINISH without driving pmod low.
REQ-016 start while busy=1 SHALL be ignored, and count SHALL NOT be re-sampled.
REQ-017 PRESS_BOUNCE: 2*BOUNCE_EDGES half-periods of BOUNCE_TIME cycles, alternating low/high, starting low; then HOLD.
REQ-018 HOLD: pmod low for HOLD_TIME cycles; then RELEASE_BOUNCE, or GAP if BOUNCE_EDGES=0.
REQ-019 RELEASE_BOUNCE: 2*BOUNCE_EDGES half-periods alternating high/low, starting high; then GAP.
REQ-020 GAP: pmod high for GAP_TIME cycles; led increments by 1 on GAP entry.
REQ-021 At end of GAP: if presses emitted = latched count, enter FINISH; otherwise enter PRESS_BOUNCE/HOLD.
REQ-022 FINISH: done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE.
REQ-023 busy SHALL be 1 from the cycle after start is accepted until the cycle before FINISH.
REQ-024 pmod SHALL go low in the first cycle after start is accepted: one-cycle latency.
REQ-025 Per-press period = 4*BOUNCE_EDGES*BOUNCE_TIME + HOLD_TIME + GAP_TIME cycles, exactly.
REQ-026 Phase timer is 24-bit; it resets to 0 on every state or half-period change and never wraps within a phase.
REQ-027 led SHALL saturate at the latched count (max 15) and hold its value in IDLE after done.
REQ-028 The press counter is 4-bit; count=15 SHALL emit exactly 15 presses with no wrap.

Reset
REQ-029 rst_n=0 SHALL immediately force pmod=1, busy=0, done=0, led=0, state IDLE, and clear all timers, including mid-burst.
REQ-030 After rst_n deasserts, the block SHALL emit nothing until a new start.

Structure
REQ-031 Shared package button_pkg SHALL hold the state encoding localparams and the default timing constants.
REQ-032 One sub-module, phase_timer (24-bit load/count/expire), SHALL be used for all timed phases.

Verification
Bench parameters: BOUNCE_TIME=2, BOUNCE_EDGES=2, HOLD_TIME=10, GAP_TIME=10, giving a 36-cycle period.
REQ-033 start with count=1 -> pmod low at cycle 1; pattern L,L,H,H,L,L,H,H then 10 L, 8 bounce, 10 H; done at cycle 37; led=1.
REQ-034 start with count=3 -> exactly 3 falling-then-stable presses with 36-cycle spacing; done once; led=3.
REQ-035 start with count=0 -> done the next cycle; pmod never low; busy never 1; led=0.
REQ-036 Second start pulse during a burst of count=2 -> ignored; exactly 2 presses emitted.
REQ-037 rst_n low at cycle 15 of a count=4 burst -> pmod=1 and busy=0 asynchronously; no done; idle afterwards.
REQ-038 BOUNCE_EDGES=0 with count=2 -> clean presses of 10 L / 10 H; done at cycle 41; led=2.
